// File: rtl/link_pkg.sv
// Shared constants and types for the inter-board move link.
// Default frame/timeout lengths are derived from the clock and baud rate.
package link_pkg;

  localparam int CLK_HZ    = 65_000_000;
  localparam int BAUD_RATE = 9_600;
  localparam int DIVISOR   = (CLK_HZ + BAUD_RATE / 2) / BAUD_RATE;

  localparam int FRAME_CYCLES_DEF = DIVISOR * 10;
  localparam int ACK_TIMEOUT_DEF  = CLK_HZ / 10;

  // Row nibble above 8 keeps this code out of the legal move space.
  localparam logic [7:0] ACK_BYTE = 8'hAA;

  typedef enum logic [1:0] {
    LINK_IDLE,
    LINK_REQ,
    LINK_FRAME,
    LINK_WAIT_ACK
  } link_state_t;

endpackage

// File: rtl/move_link_ctrl_if.sv
// Signal bundle between game_fsm / rx / tx and the link controller.
// slave is the controller side, master the surrounding logic.
interface move_link_ctrl_if #(
  parameter int PKT_LEN = 8
);

  logic               send_req;
  logic [PKT_LEN-1:0] send_move;
  logic               rx_valid;
  logic [PKT_LEN-1:0] rx_data;
  logic               tx_trigger;
  logic [PKT_LEN-1:0] tx_data;
  logic               move_valid;
  logic [PKT_LEN-1:0] move_out;
  logic               sent_ok;
  logic               link_error;
  logic               busy;

  modport master (
    output send_req, send_move, rx_valid, rx_data,
    input  tx_trigger, tx_data, move_valid, move_out,
    input  sent_ok, link_error, busy
  );

  modport slave (
    input  send_req, send_move, rx_valid, rx_data,
    output tx_trigger, tx_data, move_valid, move_out,
    output sent_ok, link_error, busy
  );

endinterface

// File: rtl/link_tx_arb.sv
// Single-transmitter arbiter: ACK beats move, one frame at a time.
// tx_data is held from the trigger until the next grant.
module link_tx_arb #(
  parameter int               PKT_LEN      = 8,
  parameter int               FRAME_CYCLES = 20,
  parameter logic [PKT_LEN-1:0] ACK_BYTE   = 8'hAA
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ack_req_i,
  input  logic               move_req_i,
  input  logic [PKT_LEN-1:0] move_byte_i,
  output logic               ack_gnt_o,
  output logic               move_gnt_o,
  output logic               idle_o,
  output logic               tx_trigger_o,
  output logic [PKT_LEN-1:0] tx_data_o
);

  localparam int TW = $clog2(FRAME_CYCLES) + 1;
  // The trigger cycle itself is the first frame cycle, so the
  // timer holds the frame cycles still to come after it.
  localparam logic [TW-1:0] LOAD = TW'(FRAME_CYCLES - 1);

  logic [TW-1:0]      timer_q;
  logic               trig_q;
  logic [PKT_LEN-1:0] data_q;

  // Grant decision: only with the line free, ACK first.
  always_comb begin
    idle_o     = (timer_q == '0);
    ack_gnt_o  = idle_o & ack_req_i;
    move_gnt_o = idle_o & move_req_i & ~ack_req_i;
  end

  // Trigger pulse, held byte and saturating frame timer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      timer_q <= '0;
      trig_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      trig_q <= ack_gnt_o | move_gnt_o;
      if (ack_gnt_o) begin
        data_q <= ACK_BYTE;
      end else if (move_gnt_o) begin
        data_q <= move_byte_i;
      end
      if (ack_gnt_o | move_gnt_o) begin
        timer_q <= LOAD;
      end else if (timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

  assign tx_trigger_o = trig_q;
  assign tx_data_o    = data_q;

endmodule

// File: rtl/move_link_ctrl.sv
// Move link controller: acked/retried sends, deduped receive path,
// and ACK replies sharing the one transmitter.
module move_link_ctrl #(
  parameter int               PKT_LEN      = 8,
  parameter int               FRAME_CYCLES = link_pkg::FRAME_CYCLES_DEF,
  parameter int               ACK_TIMEOUT  = link_pkg::ACK_TIMEOUT_DEF,
  parameter int               MAX_RETRY    = 3,
  parameter logic [PKT_LEN-1:0] ACK_BYTE   = PKT_LEN'(link_pkg::ACK_BYTE)
) (
  input logic            clk_in,
  input logic            rst_in,
  move_link_ctrl_if.slave lnk
);

  import link_pkg::*;

  localparam int TOW = $clog2(ACK_TIMEOUT) + 1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TOW-1:0] TO_LOAD   = TOW'(ACK_TIMEOUT);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

  link_state_t        state_q, state_d;
  logic [PKT_LEN-1:0] mv_q, mv_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [TOW-1:0]     tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               ok_q, ok_d;
  logic               mvalid_q, pend_q, arm_q;
  logic [PKT_LEN-1:0] mout_q;

  logic is_ack, ack_rx, byte_rx, deliver;
  logic move_req, arm_clr;
  logic ack_gnt, move_gnt, frame_idle;

  // Classify the received byte; resends of the last move are not delivered.
  always_comb begin
    is_ack  = (lnk.rx_data == ACK_BYTE);
    ack_rx  = lnk.rx_valid & is_ack;
    byte_rx = lnk.rx_valid & ~is_ack;
    deliver = byte_rx & ~(arm_q & (lnk.rx_data == mout_q));
  end

  // Send FSM next state and per-state actions.
  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    ok_d     = 1'b0;
    move_req = 1'b0;
    arm_clr  = 1'b0;
    unique case (state_q)
      LINK_IDLE: begin
        if (lnk.send_req) begin
          mv_d    = lnk.send_move;
          err_d   = 1'b0;
          retry_d = '0;
          arm_clr = 1'b1;
          state_d = LINK_REQ;
        end
      end
      LINK_REQ: begin
        move_req = 1'b1;
        if (move_gnt) state_d = LINK_FRAME;
      end
      LINK_FRAME: begin
        if (frame_idle) begin
          tmo_d   = TO_LOAD;
          state_d = LINK_WAIT_ACK;
        end
      end
      LINK_WAIT_ACK: begin
        if (ack_rx) begin
          ok_d    = 1'b1;
          state_d = LINK_IDLE;
        end else if (tmo_q == '0) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = LINK_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = LINK_IDLE;
          end
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  // State registers for the send path and the receive/ACK bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= LINK_IDLE;
      mv_q     <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      ok_q     <= 1'b0;
      mvalid_q <= 1'b0;
      mout_q   <= '0;
      pend_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mv_q     <= mv_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      ok_q     <= ok_d;
      mvalid_q <= deliver;
      if (deliver) mout_q <= lnk.rx_data;
      // A byte landing on the grant cycle still needs its own ACK.
      if (byte_rx) begin
        pend_q <= 1'b1;
      end else if (ack_gnt) begin
        pend_q <= 1'b0;
      end
      if (deliver) begin
        arm_q <= 1'b1;
      end else if (arm_clr) begin
        arm_q <= 1'b0;
      end
    end
  end

  link_tx_arb #(
    .PKT_LEN      (PKT_LEN),
    .FRAME_CYCLES (FRAME_CYCLES),
    .ACK_BYTE     (ACK_BYTE)
  ) u_arb (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .ack_req_i    (pend_q),
    .move_req_i   (move_req),
    .move_byte_i  (mv_q),
    .ack_gnt_o    (ack_gnt),
    .move_gnt_o   (move_gnt),
    .idle_o       (frame_idle),
    .tx_trigger_o (lnk.tx_trigger),
    .tx_data_o    (lnk.tx_data)
  );

  assign lnk.move_valid = mvalid_q;
  assign lnk.move_out   = mout_q;
  assign lnk.sent_ok    = ok_q;
  assign lnk.link_error = err_q;
  assign lnk.busy       = (state_q != LINK_IDLE);

endmodule

// File: tb/tb_move_link_ctrl.sv
// Bench for move_link_ctrl: directed link scenarios plus randomized
// receive/send traffic against an event-level reference model.
module tb_move_link_ctrl;

  localparam int F = 20;
  localparam int A = 100;
  localparam int R = 2;
  localparam logic [7:0] ACK = 8'hAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  move_link_ctrl_if #(.PKT_LEN(8)) lnk ();

  move_link_ctrl #(
    .PKT_LEN      (8),
    .FRAME_CYCLES (F),
    .ACK_TIMEOUT  (A),
    .MAX_RETRY    (R),
    .ACK_BYTE     (ACK)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .lnk    (lnk)
  );

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int mv_n = 0, ok_n = 0, ack_n = 0;
  int mv_t = -1, ok_t = -1;
  int trig_t[$];
  logic [7:0] trig_d[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lnk.tx_trigger) begin
      if (trig_t.size() > 0)
        check("trig_gap", 32'((cyc - trig_t[$]) >= F), 32'd1);
      trig_t.push_back(cyc);
      trig_d.push_back(lnk.tx_data);
      if (lnk.tx_data == ACK) ack_n++;
    end
    if (lnk.move_valid) begin
      mv_n++;
      mv_t = cyc;
    end
    if (lnk.sent_ok) begin
      ok_n++;
      ok_t = cyc;
    end
  end

  function automatic int tt(int i);
    return (i < trig_t.size()) ? trig_t[i] : -1;
  endfunction

  function automatic logic [7:0] td(int i);
    return (i < trig_d.size()) ? trig_d[i] : 8'h00;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    step(c - cyc);
  endtask

  task automatic send(input logic [7:0] m);
    lnk.send_req  = 1'b1;
    lnk.send_move = m;
    step();
    lnk.send_req  = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    lnk.rx_valid = 1'b1;
    lnk.rx_data  = b;
    step();
    lnk.rx_valid = 1'b0;
  endtask

  task automatic wait_trig(input int n, input int budget, input string tag);
    int k = 0;
    while (trig_t.size() < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_wait"}, 32'(trig_t.size() >= n), 32'd1);
  endtask

  task automatic scen_send_ack(input string tag);
    int base, okb, t0, a;
    base = trig_t.size();
    okb  = ok_n;
    t0   = cyc;
    send(8'h34);
    wait_trig(base + 1, 10, tag);
    check({tag, "_lat"}, 32'(tt(base) - t0), 32'd2);
    check({tag, "_dat"}, 32'(td(base)), 32'h34);
    check({tag, "_busy1"}, 32'(lnk.busy), 32'd1);
    step_to(tt(base) + F + 10);
    a = cyc;
    rx(ACK);
    step(3);
    check({tag, "_ok_n"}, 32'(ok_n - okb), 32'd1);
    check({tag, "_ok_t"}, 32'(ok_t - a), 32'd1);
    check({tag, "_ntrig"}, 32'(trig_t.size() - base), 32'd1);
    check({tag, "_busy0"}, 32'(lnk.busy), 32'd0);
    check({tag, "_err"}, 32'(lnk.link_error), 32'd0);
  endtask

  initial begin : wdog
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int base, okb, mvb, ab, t0, e, k;
    logic [7:0] pool [3];
    logic       armed;
    logic [7:0] last, b, m;
    pool = '{8'h11, 8'h52, 8'h83};

    lnk.send_req  = 1'b0;
    lnk.send_move = '0;
    lnk.rx_valid  = 1'b0;
    lnk.rx_data   = '0;

    step(3);
    check("rst_trig", 32'(lnk.tx_trigger), 32'd0);
    check("rst_txd", 32'(lnk.tx_data), 32'd0);
    check("rst_mv", 32'(lnk.move_valid), 32'd0);
    check("rst_mout", 32'(lnk.move_out), 32'd0);
    check("rst_ok", 32'(lnk.sent_ok), 32'd0);
    check("rst_err", 32'(lnk.link_error), 32'd0);
    check("rst_busy", 32'(lnk.busy), 32'd0);
    rst = 1'b0;
    step(2);

    scen_send_ack("s1");
    step(5);

    base = trig_t.size();
    okb  = ok_n;
    send(8'h34);
    wait_trig(base + 3, 3 * (F + A + 10) + 20, "s2");
    for (int i = 0; i < 3; i++)
      check("s2_dat", 32'(td(base + i)), 32'h34);
    for (int i = 1; i < 3; i++) begin
      k = tt(base + i) - tt(base + i - 1);
      check("s2_gap", 32'(k >= F + A - 2 && k <= F + A + 8), 32'd1);
    end
    check("s2_err_early", 32'(lnk.link_error), 32'd0);
    k = 0;
    while (!lnk.link_error && k < F + A + 40) begin
      step();
      k++;
    end
    e = cyc - tt(base + 2);
    check("s2_err", 32'(lnk.link_error), 32'd1);
    check("s2_err_t", 32'(e >= F + A && e <= F + A + 6), 32'd1);
    check("s2_busy", 32'(lnk.busy), 32'd0);
    step(F + A);
    check("s2_ntrig", 32'(trig_t.size() - base), 32'd3);
    check("s2_ok", 32'(ok_n - okb), 32'd0);
    check("s2_err_hold", 32'(lnk.link_error), 32'd1);
    send(8'h34);
    check("s2_err_clr", 32'(lnk.link_error), 32'd0);
    wait_trig(base + 4, 10, "s2b");
    step_to(tt(base + 3) + F + 5);
    rx(ACK);
    step(3);
    check("s2_ok2", 32'(ok_n - okb), 32'd1);
    step(5);

    base = trig_t.size();
    mvb  = mv_n;
    ab   = ack_n;
    t0   = cyc;
    rx(8'h52);
    step(2);
    check("s3_mv_t", 32'(mv_t - t0), 32'd1);
    check("s3_mout", 32'(lnk.move_out), 32'h52);
    check("s3_ack_t", 32'(tt(base) - t0), 32'd2);
    check("s3_ack_d", 32'(td(base)), 32'(ACK));
    step(F + 10);
    rx(8'h52);
    step(F + 10);
    check("s3_mv_n", 32'(mv_n - mvb), 32'd1);
    check("s3_ack_n", 32'(ack_n - ab), 32'd2);
    check("s3_mout2", 32'(lnk.move_out), 32'h52);

    base = trig_t.size();
    mvb  = mv_n;
    okb  = ok_n;
    t0   = cyc;
    lnk.send_req  = 1'b1;
    lnk.send_move = 8'h34;
    lnk.rx_valid  = 1'b1;
    lnk.rx_data   = 8'h61;
    step();
    lnk.send_req = 1'b0;
    lnk.rx_valid = 1'b0;
    wait_trig(base + 2, F + 10, "s4");
    check("s4_mv_t", 32'(mv_t - t0), 32'd1);
    check("s4_mout", 32'(lnk.move_out), 32'h61);
    check("s4_t0", 32'(tt(base) - t0), 32'd2);
    check("s4_d0", 32'(td(base)), 32'(ACK));
    check("s4_t1", 32'(tt(base + 1) - tt(base)), 32'(F));
    check("s4_d1", 32'(td(base + 1)), 32'h34);
    step_to(tt(base + 1) + F + 5);
    rx(ACK);
    step(3);
    check("s4_ok", 32'(ok_n - okb), 32'd1);
    check("s4_mv_n", 32'(mv_n - mvb), 32'd1);
    step(5);

    base = trig_t.size();
    send(8'h34);
    wait_trig(base + 1, 10, "s5");
    step_to(tt(base) + F + 20);
    check("s5_busy", 32'(lnk.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s5_trig", 32'(lnk.tx_trigger), 32'd0);
    check("s5_txd", 32'(lnk.tx_data), 32'd0);
    check("s5_mv", 32'(lnk.move_valid), 32'd0);
    check("s5_mout", 32'(lnk.move_out), 32'd0);
    check("s5_ok", 32'(lnk.sent_ok), 32'd0);
    check("s5_err", 32'(lnk.link_error), 32'd0);
    check("s5_busy0", 32'(lnk.busy), 32'd0);
    step(F + A + 30);
    check("s5_quiet", 32'(trig_t.size() - base), 32'd1);
    check("s5_err2", 32'(lnk.link_error), 32'd0);
    scen_send_ack("s5b");
    step(5);

    armed = 1'b0;
    last  = 8'h00;
    for (int it = 0; it < 30; it++) begin
      base = trig_t.size();
      mvb  = mv_n;
      okb  = ok_n;
      case ($urandom_range(0, 4))
        0, 1, 2: begin
          if ($urandom_range(0, 3) != 0) b = pool[$urandom_range(0, 2)];
          else b = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
          rx(b);
          step(F + 5);
          if (!(armed && b == last)) begin
            check("rnd_mv", 32'(mv_n - mvb), 32'd1);
            last  = b;
            armed = 1'b1;
          end else begin
            check("rnd_dup", 32'(mv_n - mvb), 32'd0);
          end
          check("rnd_mout", 32'(lnk.move_out), 32'(last));
          check("rnd_ackn", 32'(trig_t.size() - base), 32'd1);
          check("rnd_ackd", 32'(td(base)), 32'(ACK));
        end
        3: begin
          rx(ACK);
          step(F + 5);
          check("rnd_stray_mv", 32'(mv_n - mvb), 32'd0);
          check("rnd_stray_tx", 32'(trig_t.size() - base), 32'd0);
        end
        default: begin
          m = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
          armed = 1'b0;
          send(m);
          wait_trig(base + 1, 10, "rnd_send");
          check("rnd_sdat", 32'(td(base)), 32'(m));
          step_to(tt(base) + F + $urandom_range(1, 60));
          rx(ACK);
          step(3);
          check("rnd_sok", 32'(ok_n - okb), 32'd1);
          check("rnd_sbusy", 32'(lnk.busy), 32'd0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/move_link_ctrl.md
# move_link_ctrl

Controller for the inter-board UART link: sequences outgoing move frames with acknowledgement, timeout and retry, and delivers received moves to `game_fsm` exactly once. It sits between `game_fsm` and the `tx`/`rx` pair, and it is the sole driver of the `tx` trigger. It arbitrates the single transmitter between outgoing moves and ACK replies. The goal is that a lost or corrupted frame no longer desynchronises the two boards.

## Interface
Parameters:
- `PKT_LEN`, 8: frame payload width.
- `FRAME_CYCLES`, 67_710: clocks one `tx` frame occupies (DIVISOR × 10); the transmitter is considered busy for this long after a trigger.
- `ACK_TIMEOUT`, 6_500_000: clocks (100 ms at 65 MHz) to wait for ACK, counted from the end of the frame.
- `MAX_RETRY`, 3: resends after the first attempt before declaring failure.
- `ACK_BYTE`, 8'hAA: reserved ACK code; never a legal move (row nibble > 8).

Ports:
- `clk_in` in 1: system clock (65 MHz).
- `rst_in` in 1: reset; one clock; reset is synchronous and active-high.
- `send_req` in 1: one-cycle pulse from `game_fsm` requesting transmission of `send_move`.
- `send_move` in PKT_LEN: local move; sampled only on an accepted `send_req`.
- `rx_valid` in 1: one-cycle pulse from `rx` marking a received byte.
- `rx_data` in PKT_LEN: received byte; valid with `rx_valid`.
- `tx_trigger` out 1: one-cycle pulse to `tx`.
- `tx_data` out PKT_LEN: byte for `tx`; stable from the trigger cycle until the frame ends.
- `move_valid` out 1: one-cycle pulse; a new remote move is on `move_out`.
- `move_out` out PKT_LEN: last delivered remote move; held until the next delivery.
- `sent_ok` out 1: one-cycle pulse when the local move is acknowledged.
- `link_error` out 1: sticky retry-exhaustion flag; clears on the next accepted `send_req`.
- `busy` out 1: high while the send FSM is not IDLE.

## Operation
- **Reset:** all outputs are 0. All state returns to IDLE. Retry counter, timers, pending flags and the dedupe flag are cleared. A reset mid-frame suppresses any further trigger.
- **Send FSM states:** IDLE, REQ, FRAME, WAIT_ACK.
  - IDLE: on `send_req`, latch `send_move`, clear `link_error`, set retry count to 0, go to REQ. `send_req` is ignored in any other state.
  - REQ: assert the move request to the arbiter. On grant go to FRAME.
  - FRAME: wait until the arbiter's frame timer expires, then load the timeout counter and go to WAIT_ACK.
  - WAIT_ACK: on `rx_valid` with `rx_data == ACK_BYTE`, pulse `sent_ok` and go to IDLE. On timeout with retries < MAX_RETRY, increment retries and go to REQ. Otherwise set `link_error` and go to IDLE.
- **ACK bytes** received outside WAIT_ACK are discarded.
- **Receive path:** a non-ACK `rx_valid` byte always sets `ack_pend`.
  - It is delivered via `move_valid`/`move_out` unless `dup_armed` is set and the byte equals `move_out`. In that case the byte is a resend, and it is re-ACKed only.
  - Delivery sets `dup_armed`. An accepted `send_req` clears it.
- **TX arbiter:** one transmitter, one frame at a time.
  - Grant only when the frame timer is 0.
  - ACK has priority over a move request.
  - A grant pulses `tx_trigger`, drives `tx_data` (ACK_BYTE or the latched move) and loads the frame timer with FRAME_CYCLES.
  - A second non-ACK byte arriving while `ack_pend` is already set merges into a single ACK.
- **Widths:** counters are `$clog2` of their parameter + 1. The retry counter is `$clog2(MAX_RETRY+1)`. All counters saturate at 0 and never wrap.

## Timing
- `send_req` at cycle 0 with the transmitter idle and no ACK pending: REQ at cycle 1, `tx_trigger` at cycle 2.
- Non-ACK `rx_valid` at cycle t: `move_valid`/`move_out` at t+1 and `ack_pend` at t+1. `tx_trigger` with ACK_BYTE at t+2 if the timer is 0; otherwise on the first cycle the timer reaches 0.
- ACK and move requests pending in the same cycle: the ACK triggers first. The move triggers FRAME_CYCLES cycles later.
- The timeout starts the cycle after the frame timer expires. An ACK arriving on the same cycle as the timeout wins (success, no retry).
- `sent_ok` and `link_error` update one cycle after the deciding event.

## Structure
- `link_pkg`: `ACK_BYTE`, the send-state enum (`LINK_IDLE`, `LINK_REQ`, `LINK_FRAME`, `LINK_WAIT_ACK`), and default `FRAME_CYCLES`/`ACK_TIMEOUT` derived from CLK_HZ and BAUD_RATE.
- One sub-module, `link_tx_arb`, holds the priority grant, the frame timer and the `tx_data` mux. The send FSM, receive dedupe and timeout stay in the top.

## Test plan
Bench parameters: FRAME_CYCLES=20, ACK_TIMEOUT=100, MAX_RETRY=2.
- **Send and ACK:** `send_req`, `send_move=8'h34`; `rx` ACK 10 cycles after the frame ends -> exactly one `tx_trigger` with 8'h34, `sent_ok` pulses once, `busy` falls, `link_error` stays 0.
- **Retry exhaustion:** no ACK ever arrives -> three `tx_trigger`s of 8'h34, each about 120 cycles apart. `link_error` goes to 1 after the third timeout, and the next `send_req` clears it.
- **Lost ACK:** receive 8'h52 twice with no intervening `send_req` -> one `move_valid` (`move_out=8'h52`) and two ACK triggers.
- **Simultaneous requests:** remote move and `send_req` in the same cycle -> ACK_BYTE triggers first, 8'h34 triggers 20 cycles later, and both are delivered or acknowledged correctly.
- **Mid-operation reset:** `rst_in` during WAIT_ACK -> all outputs are 0 next cycle, no further triggers, and a fresh `send_req` behaves like the first scenario.
